hcsr04_echo_emulator: RTL

Synthesizable model of the HC-SR04 ultrasonic sensor: the responder end of the trigger/echo protocol. Accepts a trigger pulse, waits the burst delay, then drives echo high for distance_cm × 58 µs. Used on-board and in benches as the sensor side opposite the echo-width/cm measurement logic, so the distance path can be closed-loop tested without hardware.

---
 rtl/hcsr04_echo_emulator_pkg.sv | 29 ++
 rtl/us_tick_gen.sv | 31 +++
 rtl/hcsr04_echo_emulator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hcsr04_echo_emulator_pkg.sv
// Shared HC-SR04 protocol constants and FSM encoding, also imported by the
// echo-width measurement side so both ends agree on timing.
package hcsr04_echo_emulator_pkg;

    localparam int HC_CLK_PER_US     = 100;
    localparam int HC_US_PER_CM      = 58;
    localparam int HC_TRIG_MIN_US    = 10;
    localparam int HC_BURST_DELAY_US = 200;
    localparam int HC_MAX_CM         = 400;
    localparam int HC_TIMEOUT_US     = 38000;
    localparam int HC_HOLDOFF_US     = 10000;

    localparam int CNT_W  = 16;
    localparam int DIST_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG_HI,
        ST_BURST,
        ST_ECHO,
        ST_HOLDOFF
    } state_e;

    // Zero and anything beyond the sensor's range both produce a timeout echo.
    function automatic logic out_of_range(input logic [DIST_W-1:0] cm, input int max_cm);
        return (cm == '0) || (int'(cm) > max_cm);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every CLK_PER_US clocks, restarted by
// a synchronous clear so a timed state always starts on a whole microsecond.
module us_tick_gen #(
    parameter int CLK_PER_US = 100
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = !i_clr && (r_cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: validates a trigger pulse, waits the burst delay, then
// drives echo for distance x US_PER_CM microseconds (or the timeout width).
module hcsr04_echo_emulator
    import hcsr04_echo_emulator_pkg::*;
#(
    parameter int CLK_PER_US     = HC_CLK_PER_US,
    parameter int US_PER_CM      = HC_US_PER_CM,
    parameter int TRIG_MIN_US    = HC_TRIG_MIN_US,
    parameter int BURST_DELAY_US = HC_BURST_DELAY_US,
    parameter int MAX_CM         = HC_MAX_CM,
    parameter int TIMEOUT_US     = HC_TIMEOUT_US,
    parameter int HOLDOFF_US     = HC_HOLDOFF_US
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trig,
    input  logic [DIST_W-1:0] distance_cm,
    output logic              echo,
    output logic              busy,
    output logic              done,
    output logic              trig_err
);

    localparam logic [CNT_W-1:0] TRIG_MIN_CYC = CNT_W'(TRIG_MIN_US * CLK_PER_US);
    localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_DELAY_US - 1);
    localparam logic [CNT_W-1:0] SUB_LAST     = CNT_W'(US_PER_CM - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_US - 1);

    state_e            r_state;
    logic              r_trig_meta;
    logic              r_trig_s;
    logic              r_trig_d;
    logic [CNT_W-1:0]  r_hi_cnt;
    logic [CNT_W-1:0]  r_us;
    logic [CNT_W-1:0]  r_cm;
    logic [CNT_W-1:0]  r_sub;
    logic [DIST_W-1:0] r_dist;
    logic              r_timeout;

    logic              w_rise;
    logic              w_tick;
    logic              w_clr;
    logic              w_echo_end;

    assign w_rise = r_trig_s && !r_trig_d;

    // Timed states always exit on a tick, which wraps the prescaler to zero,
    // so only the untimed states need to hold it cleared.
    assign w_clr = (r_state == ST_IDLE) || (r_state == ST_TRIG_HI);

    assign w_echo_end = w_tick && (r_timeout ? (r_us == TIMEOUT_LAST)
                                             : ((r_sub == SUB_LAST) &&
                                                (r_cm == CNT_W'(r_dist) - 1'b1)));

    us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_meta <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_d    <= 1'b0;
        end else begin
            r_trig_meta <= trig;
            r_trig_s    <= r_trig_meta;
            r_trig_d    <= r_trig_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_hi_cnt  <= '0;
            r_us      <= '0;
            r_cm      <= '0;
            r_sub     <= '0;
            r_dist    <= '0;
            r_timeout <= 1'b0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            trig_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_hi_cnt <= CNT_W'(1);
                        r_state  <= ST_TRIG_HI;
                    end
                end
                ST_TRIG_HI: begin
                    if (r_trig_s) begin
                        if (r_hi_cnt != '1) r_hi_cnt <= r_hi_cnt + 1'b1;
                    end else if (r_hi_cnt >= TRIG_MIN_CYC) begin
                        r_dist    <= distance_cm;
                        r_timeout <= out_of_range(distance_cm, MAX_CM);
                        r_us      <= '0;
                        busy      <= 1'b1;
                        r_state   <= ST_BURST;
                    end else begin
                        trig_err <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (w_tick) begin
                        if (r_us == BURST_LAST) begin
                            r_us    <= '0;
                            r_cm    <= '0;
                            r_sub   <= '0;
                            echo    <= 1'b1;
                            r_state <= ST_ECHO;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                ST_ECHO: begin
                    if (w_echo_end) begin
                        r_us    <= '0;
                        echo    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_HOLDOFF;
                    end else if (w_tick) begin
                        if (r_timeout) begin
                            r_us <= r_us + 1'b1;
                        end else if (r_sub == SUB_LAST) begin
                            r_sub <= '0;
                            r_cm  <= r_cm + 1'b1;
                        end else begin
                            r_sub <= r_sub + 1'b1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (w_tick) begin
                        if (r_us == HOLDOFF_LAST) begin
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
